// File: rtl/main_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl_pkg
//   Shared types and widths for the main-memory controller and the cache miss
//   ports that talk to it.
//
//   Contents:
//     MAIN_MEM_BLOCK_ADDR_WIDTH / main_mem_block_addr_t : block address
//     BLOCK_DATA_WIDTH / block_data_t                   : one cache block
//     req_type_t       : dcache request kind (READ = 0, WRITE = 1)
//     mem_ctrl_state_t : controller FSM states
//     mem_ctrl_port_t  : requesting port identity (ICACHE / DCACHE)
//     rr_pick()        : round-robin grant helper
// ---------------------------------------------------------------------------
package main_mem_ctrl_pkg;

    localparam int MAIN_MEM_BLOCK_ADDR_WIDTH = 26;
    localparam int BLOCK_DATA_WIDTH          = 128;

    typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_ctrl_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } mem_ctrl_port_t;

    // A lone requester always wins. On a tie, the port that did not win
    // last time wins now. With no requester the result is a don't-care;
    // DCACHE is returned so the caller can qualify it with the valids.
    function automatic mem_ctrl_port_t rr_pick(input logic           icache_valid,
                                               input logic           dcache_valid,
                                               input mem_ctrl_port_t rr_last);
        mem_ctrl_port_t pick;
        if (icache_valid && dcache_valid) begin
            pick = (rr_last == DCACHE) ? ICACHE : DCACHE;
        end else if (icache_valid) begin
            pick = ICACHE;
        end else begin
            pick = DCACHE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/main_mem_ctrl_array.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl_array
//   Block-wide main-memory storage, N_BLOCKS x BLOCK_DATA_WIDTH, with a single
//   synchronous port used for either a read or a write each access.
//   The storage is never reset.
//
//   Ports:
//     clk    in   clock
//     en     in   perform an access this edge
//     we     in   1 = write wdata to mem[idx], 0 = read mem[idx]
//     idx    in   block index
//     wdata  in   write data
//     rdata  out  registered result of the last access. A write returns the
//                 written value, so the controller can echo it without a
//                 second access.
// ---------------------------------------------------------------------------
module main_mem_ctrl_array
    import main_mem_ctrl_pkg::*;
#(
    parameter int N_BLOCKS = 256,
    parameter int IDX_W    = $clog2(N_BLOCKS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  block_data_t      wdata,
    output block_data_t      rdata
);

    block_data_t mem [N_BLOCKS];
    block_data_t rdata_q;

    // rdata_q changes only on an access, so it stays stable for the whole
    // latency window of the request that produced it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
                rdata_q  <= wdata;
            end else begin
                rdata_q  <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// main_mem_ctrl
//   Main-memory controller below the icache/dcache miss ports. It arbitrates
//   between the two ports round-robin and serves one request at a time. Each
//   request gets a one-cycle response pulse exactly LATENCY cycles after it is
//   accepted, and the pulse goes only to the port that made the request.
//
//   Parameters:
//     N_BLOCKS  memory depth in blocks (index = low $clog2(N_BLOCKS) addr bits)
//     LATENCY   cycles from acceptance to response pulse, >= 1
//
//   Ports:
//     clk, rst_aL                        clock, async active-low reset
//     icache_mem_ctrl_req_valid/ready    icache block-read handshake
//     icache_mem_ctrl_req_block_addr     icache block address
//     icache_mem_ctrl_resp_valid         icache one-cycle response pulse
//     icache_mem_ctrl_resp_block_data    icache read data (holds when idle)
//     dcache_mem_ctrl_req_valid/ready    dcache request handshake
//     dcache_mem_ctrl_req_type           READ / WRITE
//     dcache_mem_ctrl_req_block_addr     dcache block address
//     dcache_mem_ctrl_req_block_data     dcache write data
//     dcache_mem_ctrl_resp_valid         dcache one-cycle response pulse
//     dcache_mem_ctrl_resp_block_data    read data or echoed write data
//
//   Optional feature, macro MAIN_MEM_CTRL_STATS_EN:
//     stats_icache_reqs, stats_dcache_rd_reqs, stats_dcache_wr_reqs
//     are saturating 32-bit counts of accepted requests of each kind.
// ---------------------------------------------------------------------------
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int N_BLOCKS = 256,
    parameter int LATENCY  = 4
) (
    input  logic                 clk,
    input  logic                 rst_aL,

    input  logic                 icache_mem_ctrl_req_valid,
    input  main_mem_block_addr_t icache_mem_ctrl_req_block_addr,
    output logic                 icache_mem_ctrl_req_ready,
    output logic                 icache_mem_ctrl_resp_valid,
    output block_data_t          icache_mem_ctrl_resp_block_data,

    input  logic                 dcache_mem_ctrl_req_valid,
    input  req_type_t            dcache_mem_ctrl_req_type,
    input  main_mem_block_addr_t dcache_mem_ctrl_req_block_addr,
    input  block_data_t          dcache_mem_ctrl_req_block_data,
    output logic                 dcache_mem_ctrl_req_ready,
    output logic                 dcache_mem_ctrl_resp_valid,
    output block_data_t          dcache_mem_ctrl_resp_block_data
`ifdef MAIN_MEM_CTRL_STATS_EN
    ,
    output logic [31:0]          stats_icache_reqs,
    output logic [31:0]          stats_dcache_rd_reqs,
    output logic [31:0]          stats_dcache_wr_reqs
`endif
);

    localparam int IDX_W = $clog2(N_BLOCKS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    mem_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_ctrl_port_t  rr_last_q, rr_last_d;
    mem_ctrl_port_t  grant_q, grant_d;
    block_data_t     icache_data_q, icache_data_d;
    block_data_t     dcache_data_q, dcache_data_d;

    mem_ctrl_port_t   pick;
    logic             accept;
    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    block_data_t      arr_rdata;
    logic             unused_addr_bits;

    // Upper address bits beyond the array depth are ignored, which makes
    // addresses alias modulo N_BLOCKS.
    assign unused_addr_bits = ^{icache_mem_ctrl_req_block_addr[MAIN_MEM_BLOCK_ADDR_WIDTH-1:IDX_W],
                                dcache_mem_ctrl_req_block_addr[MAIN_MEM_BLOCK_ADDR_WIDTH-1:IDX_W]};

    // Arbiter: grant is evaluated only in IDLE, and ready goes only to the
    // granted port when that port is requesting. At most one handshake can
    // therefore happen per cycle.
    always_comb begin
        pick   = rr_pick(icache_mem_ctrl_req_valid, dcache_mem_ctrl_req_valid, rr_last_q);
        accept = (state_q == IDLE) &&
                 (icache_mem_ctrl_req_valid || dcache_mem_ctrl_req_valid);
        icache_mem_ctrl_req_ready = accept && (pick == ICACHE);
        dcache_mem_ctrl_req_ready = accept && (pick == DCACHE);
        arr_we  = accept && (pick == DCACHE) && (dcache_mem_ctrl_req_type == WRITE);
        arr_idx = (pick == DCACHE) ? dcache_mem_ctrl_req_block_addr[IDX_W-1:0]
                                   : icache_mem_ctrl_req_block_addr[IDX_W-1:0];
    end

    // The array is touched only on the acceptance edge. Its output register
    // then holds the response data until the next acceptance. That cannot
    // happen before this response has been delivered.
    main_mem_ctrl_array #(
        .N_BLOCKS (N_BLOCKS),
        .IDX_W    (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (accept),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (dcache_mem_ctrl_req_block_data),
        .rdata (arr_rdata)
    );

    // FSM and latency counter. An acceptance loads LATENCY-1 and WAIT counts
    // down to 1, so RESP falls exactly LATENCY cycles after the accept.
    // With LATENCY == 1 the controller skips WAIT entirely.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d   = pick;
                    rr_last_d = pick;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    state_d   = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Each port's held data register captures the array output during that
    // port's RESP cycle. Between pulses the port keeps showing its own
    // last response.
    always_comb begin
        icache_data_d = icache_data_q;
        dcache_data_d = dcache_data_q;
        if (state_q == RESP) begin
            if (grant_q == ICACHE) begin
                icache_data_d = arr_rdata;
            end else begin
                dcache_data_d = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_last_q     <= DCACHE;
            grant_q       <= ICACHE;
            icache_data_q <= '0;
            dcache_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_last_q     <= rr_last_d;
            grant_q       <= grant_d;
            icache_data_q <= icache_data_d;
            dcache_data_q <= dcache_data_d;
        end
    end

    // The pulse is decoded straight from the state register, so an async
    // reset drops it immediately. During RESP the data output shows the
    // array output directly; this is what lets LATENCY == 1 meet its timing.
    assign icache_mem_ctrl_resp_valid      = (state_q == RESP) && (grant_q == ICACHE);
    assign dcache_mem_ctrl_resp_valid      = (state_q == RESP) && (grant_q == DCACHE);
    assign icache_mem_ctrl_resp_block_data = icache_mem_ctrl_resp_valid ? arr_rdata : icache_data_q;
    assign dcache_mem_ctrl_resp_block_data = dcache_mem_ctrl_resp_valid ? arr_rdata : dcache_data_q;

`ifdef MAIN_MEM_CTRL_STATS_EN
    logic [31:0] icache_reqs_q, icache_reqs_d;
    logic [31:0] dcache_rd_q,   dcache_rd_d;
    logic [31:0] dcache_wr_q,   dcache_wr_d;

    // Saturating per-kind counters of accepted requests.
    always_comb begin
        icache_reqs_d = icache_reqs_q;
        dcache_rd_d   = dcache_rd_q;
        dcache_wr_d   = dcache_wr_q;
        if (accept) begin
            if (pick == ICACHE) begin
                if (icache_reqs_q != 32'hFFFF_FFFF) icache_reqs_d = icache_reqs_q + 32'd1;
            end else if (dcache_mem_ctrl_req_type == WRITE) begin
                if (dcache_wr_q != 32'hFFFF_FFFF) dcache_wr_d = dcache_wr_q + 32'd1;
            end else begin
                if (dcache_rd_q != 32'hFFFF_FFFF) dcache_rd_d = dcache_rd_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            icache_reqs_q <= '0;
            dcache_rd_q   <= '0;
            dcache_wr_q   <= '0;
        end else begin
            icache_reqs_q <= icache_reqs_d;
            dcache_rd_q   <= dcache_rd_d;
            dcache_wr_q   <= dcache_wr_d;
        end
    end

    assign stats_icache_reqs    = icache_reqs_q;
    assign stats_dcache_rd_reqs = dcache_rd_q;
    assign stats_dcache_wr_reqs = dcache_wr_q;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_main_mem_ctrl
//   Directed bench for main_mem_ctrl. The main instance uses LATENCY = 4 and
//   N_BLOCKS = 256. A second instance uses LATENCY = 1.
//   Stats counters are checked when MAIN_MEM_CTRL_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_main_mem_ctrl;
    import main_mem_ctrl_pkg::*;

    localparam int LAT = 4;

    localparam block_data_t D1 = 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444;
    localparam block_data_t D2 = 128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_1234_5678;
    localparam block_data_t D3 = 128'hCAFE_F00D_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam block_data_t D4 = 128'h0F0F_0F0F_F0F0_F0F0_0102_0304_0506_0708;
    localparam block_data_t D5 = 128'h5555_0000_5555_0000_2020_2020_2020_2020;
    localparam block_data_t D6 = 128'hAAAA_1111_AAAA_1111_3030_3030_3030_3030;

    logic clk = 1'b0;
    logic rst_aL;
    always #5 clk = ~clk;

    logic                 i_valid, i_ready, i_rvalid;
    main_mem_block_addr_t i_addr;
    block_data_t          i_rdata;
    logic                 d_valid, d_ready, d_rvalid;
    req_type_t            d_type;
    main_mem_block_addr_t d_addr;
    block_data_t          d_wdata, d_rdata;

    logic                 l1_i_ready, l1_i_rvalid;
    block_data_t          l1_i_rdata;
    logic                 l1_d_valid, l1_d_ready, l1_d_rvalid;
    req_type_t            l1_d_type;
    main_mem_block_addr_t l1_d_addr;
    block_data_t          l1_d_wdata, l1_d_rdata;

`ifdef MAIN_MEM_CTRL_STATS_EN
    logic [31:0] s_i, s_drd, s_dwr;
    logic [31:0] l1_s_i, l1_s_drd, l1_s_dwr;
`endif

    int checks = 0;
    int errors = 0;

    main_mem_ctrl #(.N_BLOCKS(256), .LATENCY(LAT)) dut (
        .clk                             (clk),
        .rst_aL                          (rst_aL),
        .icache_mem_ctrl_req_valid       (i_valid),
        .icache_mem_ctrl_req_block_addr  (i_addr),
        .icache_mem_ctrl_req_ready       (i_ready),
        .icache_mem_ctrl_resp_valid      (i_rvalid),
        .icache_mem_ctrl_resp_block_data (i_rdata),
        .dcache_mem_ctrl_req_valid       (d_valid),
        .dcache_mem_ctrl_req_type        (d_type),
        .dcache_mem_ctrl_req_block_addr  (d_addr),
        .dcache_mem_ctrl_req_block_data  (d_wdata),
        .dcache_mem_ctrl_req_ready       (d_ready),
        .dcache_mem_ctrl_resp_valid      (d_rvalid),
        .dcache_mem_ctrl_resp_block_data (d_rdata)
`ifdef MAIN_MEM_CTRL_STATS_EN
        ,
        .stats_icache_reqs               (s_i),
        .stats_dcache_rd_reqs            (s_drd),
        .stats_dcache_wr_reqs            (s_dwr)
`endif
    );

    main_mem_ctrl #(.N_BLOCKS(256), .LATENCY(1)) dut_lat1 (
        .clk                             (clk),
        .rst_aL                          (rst_aL),
        .icache_mem_ctrl_req_valid       (1'b0),
        .icache_mem_ctrl_req_block_addr  ('0),
        .icache_mem_ctrl_req_ready       (l1_i_ready),
        .icache_mem_ctrl_resp_valid      (l1_i_rvalid),
        .icache_mem_ctrl_resp_block_data (l1_i_rdata),
        .dcache_mem_ctrl_req_valid       (l1_d_valid),
        .dcache_mem_ctrl_req_type        (l1_d_type),
        .dcache_mem_ctrl_req_block_addr  (l1_d_addr),
        .dcache_mem_ctrl_req_block_data  (l1_d_wdata),
        .dcache_mem_ctrl_req_ready       (l1_d_ready),
        .dcache_mem_ctrl_resp_valid      (l1_d_rvalid),
        .dcache_mem_ctrl_resp_block_data (l1_d_rdata)
`ifdef MAIN_MEM_CTRL_STATS_EN
        ,
        .stats_icache_reqs               (l1_s_i),
        .stats_dcache_rd_reqs            (l1_s_drd),
        .stats_dcache_wr_reqs            (l1_s_dwr)
`endif
    );

    // Count every comparison and report each mismatch on a single line.
    task automatic checkOutput(input string tag, input block_data_t got, input block_data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_of(input mem_ctrl_port_t p);
        return (p == ICACHE) ? i_ready : d_ready;
    endfunction

    function automatic logic rvalid_of(input mem_ctrl_port_t p);
        return (p == ICACHE) ? i_rvalid : d_rvalid;
    endfunction

    function automatic block_data_t rdata_of(input mem_ctrl_port_t p);
        return (p == ICACHE) ? i_rdata : d_rdata;
    endfunction

    // Assert reset for a few cycles and check the reset outputs while it
    // is held. Release happens just after a rising edge.
    task automatic applyReset();
        rst_aL = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_i_ready",  i_ready,  0);
        checkOutput("rst_d_ready",  d_ready,  0);
        checkOutput("rst_i_rvalid", i_rvalid, 0);
        checkOutput("rst_d_rvalid", d_rvalid, 0);
        checkOutput("rst_i_rdata",  i_rdata,  0);
        checkOutput("rst_d_rdata",  d_rdata,  0);
`ifdef MAIN_MEM_CTRL_STATS_EN
        checkOutput("rst_stats", {s_i, s_drd, s_dwr}, 0);
`endif
        @(posedge clk);
        #1;
        rst_aL = 1'b1;
    endtask

    // Issue one request on a single port, wait (bounded) for the accept,
    // then check the exact response timing and data, plus the hold after
    // the pulse.
    task automatic applyStimulus(input mem_ctrl_port_t p, input req_type_t typ,
                                 input main_mem_block_addr_t addr, input block_data_t wdata,
                                 input block_data_t exp_data);
        mem_ctrl_port_t other;
        bit got_ready;
        other     = (p == ICACHE) ? DCACHE : ICACHE;
        got_ready = 1'b0;
        nextCycle();
        if (p == ICACHE) begin
            i_valid = 1'b1; i_addr = addr;
        end else begin
            d_valid = 1'b1; d_type = typ; d_addr = addr; d_wdata = wdata;
        end
        for (int w = 0; w < 20 && !got_ready; w++) begin
            @(negedge clk);
            if (ready_of(p)) got_ready = 1'b1;
            else nextCycle();
        end
        if (!got_ready) begin
            checkOutput("accept_timeout", 0, 1);
            i_valid = 1'b0;
            d_valid = 1'b0;
            return;
        end
        checkOutput("other_ready_low", ready_of(other), 0);
        nextCycle();
        i_valid = 1'b0;
        d_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput("resp_valid",       rvalid_of(p),     k == LAT);
            checkOutput("other_resp_valid", rvalid_of(other), 0);
            checkOutput("ready_busy",       ready_of(p),      0);
            if (k == LAT) checkOutput("resp_data", rdata_of(p), exp_data);
            if (k < LAT) nextCycle();
        end
        nextCycle();
        @(negedge clk);
        checkOutput("resp_pulse_end", rvalid_of(p), 0);
        checkOutput("resp_data_hold", rdata_of(p),  exp_data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_valid = 0; i_addr = '0;
        d_valid = 0; d_type = READ; d_addr = '0; d_wdata = '0;
        l1_d_valid = 0; l1_d_type = READ; l1_d_addr = '0; l1_d_wdata = '0;

        applyReset();

        // Test 1: dcache write, echoed on dcache only. Test 2: icache read-back.
        applyStimulus(DCACHE, WRITE, 26'h10, D1, D1);
        applyStimulus(ICACHE, READ,  26'h10, '0, D1);

        // LATENCY = 1 instance: accept t -> response t+1 -> next accept t+2.
        nextCycle();
        l1_d_valid = 1; l1_d_type = WRITE; l1_d_addr = 26'h5; l1_d_wdata = D4;
        @(negedge clk);
        checkOutput("l1_accept", l1_d_ready, 1);
        checkOutput("l1_i_ready", l1_i_ready, 0);
        nextCycle();
        l1_d_type = READ;
        @(negedge clk);
        checkOutput("l1_wr_resp", l1_d_rvalid, 1);
        checkOutput("l1_wr_data", l1_d_rdata, D4);
        checkOutput("l1_busy", l1_d_ready, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("l1_next_accept", l1_d_ready, 1);
        checkOutput("l1_pulse_end", l1_d_rvalid, 0);
        nextCycle();
        l1_d_valid = 0;
        @(negedge clk);
        checkOutput("l1_rd_resp", l1_d_rvalid, 1);
        checkOutput("l1_rd_data", l1_d_rdata, D4);
        checkOutput("l1_i_rvalid", l1_i_rvalid, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("l1_rd_end", l1_d_rvalid, 0);
        checkOutput("l1_rd_hold", l1_d_rdata, D4);
        checkOutput("l1_i_rdata", l1_i_rdata, 0);

        // Test 5: reset in WAIT aborts the request; memory survives.
        nextCycle();
        i_valid = 1; i_addr = 26'h10;
        @(negedge clk);
        checkOutput("t5_accept", i_ready, 1);
        nextCycle();
        i_valid = 0;
        nextCycle();
        #2 rst_aL = 1'b0;
        #1;
        checkOutput("t5_rst_rvalid", i_rvalid, 0);
        checkOutput("t5_rst_rdata",  i_rdata,  0);
        checkOutput("t5_rst_d_rdata", d_rdata, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("t5_no_pulse", i_rvalid, 0);
        end
        @(posedge clk);
        #1 rst_aL = 1'b1;
        applyStimulus(ICACHE, READ, 26'h10, '0, D1);

        // Test 3: preload, reset, then hold both ports valid. Grants go
        // I, D, I at cycles 0, 5 and 10.
        applyStimulus(DCACHE, WRITE, 26'h20, D5, D5);
        applyStimulus(DCACHE, WRITE, 26'h30, D6, D6);
        applyReset();
        for (int c = 0; c <= 14; c++) begin
            nextCycle();
            if (c == 0) begin
                i_valid = 1; i_addr = 26'h20;
                d_valid = 1; d_type = READ; d_addr = 26'h30;
            end
            if (c == 11) begin
                i_valid = 0; d_valid = 0;
            end
            @(negedge clk);
            checkOutput($sformatf("t3_i_ready_c%0d", c),  i_ready,  (c == 0) || (c == 10));
            checkOutput($sformatf("t3_d_ready_c%0d", c),  d_ready,  c == 5);
            checkOutput($sformatf("t3_i_rvalid_c%0d", c), i_rvalid, (c == 4) || (c == 14));
            checkOutput($sformatf("t3_d_rvalid_c%0d", c), d_rvalid, c == 9);
            if (c == 4 || c == 14) checkOutput("t3_i_data", i_rdata, D5);
            if (c == 9) checkOutput("t3_d_data", d_rdata, D6);
        end

        // Test 4: write, then a read held valid during the write; then an alias.
        for (int c = 0; c <= 9; c++) begin
            nextCycle();
            if (c == 0) begin
                d_valid = 1; d_type = WRITE; d_addr = 26'h40; d_wdata = D2;
            end
            if (c == 1) d_type = READ;
            if (c == 6) d_valid = 0;
            @(negedge clk);
            checkOutput($sformatf("t4_d_ready_c%0d", c),  d_ready,  (c == 0) || (c == 5));
            checkOutput($sformatf("t4_d_rvalid_c%0d", c), d_rvalid, (c == 4) || (c == 9));
            checkOutput($sformatf("t4_i_rvalid_c%0d", c), i_rvalid, 0);
            if (c == 4 || c == 9) checkOutput("t4_d_data", d_rdata, D2);
        end
        applyStimulus(DCACHE, READ, 26'h140, '0, D2);

        // Mixed sequence for the stats counters: 3 I, 2 D reads, 1 D write.
        applyReset();
        applyStimulus(ICACHE, READ,  26'h10, '0, D1);
        applyStimulus(DCACHE, WRITE, 26'h60, D3, D3);
        applyStimulus(DCACHE, READ,  26'h60, '0, D3);
        applyStimulus(ICACHE, READ,  26'h60, '0, D3);
        applyStimulus(DCACHE, READ,  26'h10, '0, D1);
        applyStimulus(ICACHE, READ,  26'h20, '0, D5);
`ifdef MAIN_MEM_CTRL_STATS_EN
        checkOutput("stats_icache",    s_i,   3);
        checkOutput("stats_dcache_rd", s_drd, 2);
        checkOutput("stats_dcache_wr", s_dwr, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
